// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, load-use stall and bubble insertion.
// Define FORWARD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module id_ex_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_dst_i,
  input  logic [31:0] id_rs_data_i,
  input  logic [31:0] id_rt_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_shamt_i,
  input  logic [4:0]  id_alu_ctl_i,
  input  logic        id_sign_i,
  input  logic        id_alusrc_i,
  input  logic        id_shamt_sel_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        id_memwrite_i,
  input  logic        id_memtoreg_i,
  input  logic        flush_i,
  input  logic        exmem_wen_i,
  input  logic [4:0]  exmem_dst_i,
  input  logic [31:0] exmem_result_i,
  input  logic        memwb_wen_i,
  input  logic [4:0]  memwb_dst_i,
  input  logic [31:0] memwb_data_i,
  output logic        stall_o,
  output logic [31:0] alu_in1_o,
  output logic [31:0] alu_in2_o,
  output logic [4:0]  alu_ctl_o,
  output logic        alu_sign_o,
  output logic        ex_valid_o,
  output logic        ex_regwrite_o,
  output logic        ex_memread_o,
  output logic        ex_memwrite_o,
  output logic        ex_memtoreg_o,
  output logic [4:0]  ex_dst_o,
  output logic [31:0] ex_store_data_o
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  alu_ctl;
    logic        sign;
    logic        alusrc;
    logic        shamt_sel;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
  } ex_reg_t;

  ex_reg_t     ex_q, ex_d;
  logic        rt_read;
  logic        load_use;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // rt is a true source for R-type ops and for stores (store data), not for I-type ALU ops.
  assign rt_read  = !id_alusrc_i | id_memwrite_i;
  assign load_use = id_valid_i & ex_q.valid & ex_q.memread & (ex_q.dst != 5'd0) &
                    ((ex_q.dst == id_rs_i) | ((ex_q.dst == id_rt_i) & rt_read));

`ifdef FORWARD_EN
  assign stall_o = load_use;

  // EX/MEM is the younger producer, so it wins over MEM/WB; register 0 is never forwarded.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    fwd_rt = ex_q.rt_data;
    if (exmem_wen_i && (exmem_dst_i != 5'd0) && (exmem_dst_i == ex_q.rs)) begin
      fwd_rs = exmem_result_i;
    end else if (memwb_wen_i && (memwb_dst_i != 5'd0) && (memwb_dst_i == ex_q.rs)) begin
      fwd_rs = memwb_data_i;
    end
    if (exmem_wen_i && (exmem_dst_i != 5'd0) && (exmem_dst_i == ex_q.rt)) begin
      fwd_rt = exmem_result_i;
    end else if (memwb_wen_i && (memwb_dst_i != 5'd0) && (memwb_dst_i == ex_q.rt)) begin
      fwd_rt = memwb_data_i;
    end
  end
`else
  logic rs_used;
  logic rt_used;
  logic raw_hit;
  logic unused_fwd;

  assign rs_used = !id_shamt_sel_i & (id_rs_i != 5'd0);
  assign rt_used = rt_read & (id_rt_i != 5'd0);

  // Without forwarding, hold ID until the producer has left EX and MEM (WB writes through).
  assign raw_hit = id_valid_i & (
      (rs_used & ((ex_q.regwrite & (ex_q.dst == id_rs_i)) |
                  (exmem_wen_i & (exmem_dst_i == id_rs_i)))) |
      (rt_used & ((ex_q.regwrite & (ex_q.dst == id_rt_i)) |
                  (exmem_wen_i & (exmem_dst_i == id_rt_i)))));

  assign stall_o = load_use | raw_hit;
  assign fwd_rs  = ex_q.rs_data;
  assign fwd_rt  = ex_q.rt_data;

  assign unused_fwd = ^{exmem_result_i, memwb_wen_i, memwb_dst_i, memwb_data_i, ex_q.rs, ex_q.rt};
`endif

  // A bubble is an all-zero record: invalid, no writes, alu_ctl 0 (AND).
  always_comb begin
    ex_d = '0;
    if (!(flush_i || stall_o)) begin
      ex_d.valid     = id_valid_i;
      ex_d.rs        = id_rs_i;
      ex_d.rt        = id_rt_i;
      ex_d.dst       = id_dst_i;
      ex_d.rs_data   = id_rs_data_i;
      ex_d.rt_data   = id_rt_data_i;
      ex_d.imm       = id_imm_i;
      ex_d.shamt     = id_shamt_i;
      ex_d.alu_ctl   = id_alu_ctl_i;
      ex_d.sign      = id_sign_i;
      ex_d.alusrc    = id_alusrc_i;
      ex_d.shamt_sel = id_shamt_sel_i;
      ex_d.regwrite  = id_regwrite_i & id_valid_i;
      ex_d.memread   = id_memread_i & id_valid_i;
      ex_d.memwrite  = id_memwrite_i & id_valid_i;
      ex_d.memtoreg  = id_memtoreg_i & id_valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign alu_in1_o       = ex_q.shamt_sel ? {27'b0, ex_q.shamt} : fwd_rs;
  assign alu_in2_o       = ex_q.alusrc ? ex_q.imm : fwd_rt;
  assign ex_store_data_o = fwd_rt;
  assign alu_ctl_o       = ex_q.alu_ctl;
  assign alu_sign_o      = ex_q.sign;
  assign ex_valid_o      = ex_q.valid;
  assign ex_regwrite_o   = ex_q.regwrite;
  assign ex_memread_o    = ex_q.memread;
  assign ex_memwrite_o   = ex_q.memwrite;
  assign ex_memtoreg_o   = ex_q.memtoreg;
  assign ex_dst_o        = ex_q.dst;

endmodule
